serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: N, default 4, operand/result width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand request present.
REQ-005 in_ready  output  1  block can accept an operand request.
REQ-006 a  input  N  operand A, unsigned/two's complement.
REQ-007 b  input  N  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1).
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 s  output  N  sum/difference.
REQ-012 cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-013 ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-014 zero  output  1  s == 0.

Function
REQ-015 The block SHALL be a bit-serial adder/subtractor with a single 1-bit full adder, processing one bit per clock, LSB first.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE -> BUSY on the edge where in_valid && in_ready; a, b, sub latched on that edge; carry register loaded with sub; bit index cleared to 0.
REQ-019 In BUSY, each edge SHALL compute bit i: s[i] = a[i] ^ (b[i]^sub) ^ c, c <= majority(a[i], b[i]^sub, c), i <= i+1.
REQ-020 BUSY -> DONE on the edge processing bit N-1; cout, ovf, zero registered on that same edge.
REQ-021 Latency: out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-022 DONE -> IDLE on the edge where out_valid && out_ready; in_ready rises the following cycle (no same-cycle accept during DONE).
REQ-023 s, cout, ovf, zero SHALL hold stable in DONE while out_ready is 0, and SHALL hold their last values in IDLE.
REQ-024 Inputs a, b, sub, in_valid SHALL be ignored outside IDLE.
REQ-025 Arithmetic SHALL wrap modulo 2^N; no saturation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, s 0, cout 0, ovf 0, zero 1, carry 0, bit index 0.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-028 Macro SERIAL_ADDSUB_ACCUM_EN: when defined, an extra input acc_sel (1 bit) SHALL exist; if acc_sel = 1 at acceptance, the current s register replaces a as operand A (running accumulator, starts at 0 after reset).
REQ-029 Without SERIAL_ADDSUB_ACCUM_EN, acc_sel SHALL not exist and operand A is always port a.

Verification
REQ-030 N=4, a=0110, b=0110, sub=0 -> after 4 cycles s=1100, cout=0, ovf=1, zero=0.
REQ-031 a=0110, b=0110, sub=1 -> s=0000, cout=1, ovf=0, zero=1.
REQ-032 a=0110, b=0111, sub=1 -> s=1111, cout=0, ovf=0; a=1111, b=0001, sub=0 -> s=0000, cout=1, zero=1.
REQ-033 Hold out_ready=0 for 3 cycles in DONE -> out_valid and s stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-034 Assert rst_n=0 after 2 BUSY cycles -> all outputs at reset values immediately, out_valid never rises for that request.
REQ-035 With SERIAL_ADDSUB_ACCUM_EN: after reset, three requests acc_sel=1, b=0011, sub=0 -> s = 0011, 0110, 1001.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one full adder, LSB first, valid/ready handshake
// Optional accumulator operand select under `define SERIAL_ADDSUB_ACCUM_EN (adds input acc_sel).
module serial_addsub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
`ifdef SERIAL_ADDSUB_ACCUM_EN
  input  logic         acc_sel,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          c_q, c_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [N-1:0]  op_a;
  logic          fa_a, fa_b, fa_sum, fa_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    op_a = a;
`ifdef SERIAL_ADDSUB_ACCUM_EN
    if (acc_sel) op_a = s_q;
`endif

    // b is stored pre-inverted for subtract, so the adder never sees sub
    fa_a   = a_q[idx_q];
    fa_b   = b_q[idx_q];
    fa_sum = fa_a ^ fa_b ^ c_q;
    fa_c   = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          a_d     = op_a;
          b_d     = b ^ {N{sub}};
          c_d     = sub;
          idx_d   = '0;
        end
      end
      BUSY: begin
        s_d[idx_q] = fa_sum;
        c_d        = fa_c;
        idx_d      = idx_q + IW'(1);
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          zero_d  = (s_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
